count_pwm_gen: RTL and testbench

COUNT_PWM_GEN -- requirements
Module: count_pwm_gen

---
 rtl/count_pwm_pkg.sv | 13 +
 rtl/count_pwm_if.sv | 32 +++
 rtl/count_pwm_gen_seq.sv | 31 +++
 rtl/count_pwm_gen.sv | 113 +++++++++++
 tb/tb_count_pwm_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/count_pwm_pkg.sv
// Shared constants for the count-driven PWM generator:
// default widths and the FSM state encoding.
package count_pwm_pkg;

   localparam int CW_DEF = 4;
   localparam int PW_DEF = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/count_pwm_if.sv
// Signal bundle between the PWM generator and its controller:
// the upstream count plus control inputs, and the status outputs.
interface count_pwm_if
   import count_pwm_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int PW = PW_DEF
);

   logic [CW-1:0] count;
   logic          en;
   logic [CW-1:0] duty_in;
   logic          duty_wr;
   logic          err_clr;
   logic          pwm;
   logic          wrap;
   logic [CW-1:0] duty_act;
   logic [PW-1:0] periods;
   logic          seq_err;
   logic [1:0]    state;

   modport master (
      output count, en, duty_in, duty_wr, err_clr,
      input  pwm, wrap, duty_act, periods, seq_err, state
   );

   modport slave (
      input  count, en, duty_in, duty_wr, err_clr,
      output pwm, wrap, duty_act, periods, seq_err, state
   );

endinterface

// File: rtl/count_pwm_gen_seq.sv
// Tracks the previous count and flags period boundaries and
// discontinuities (anything other than hold or +1 mod 2^CW).
module count_seq_detect
   import count_pwm_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] count,
   output logic          boundary,
   output logic          disc
);

   logic [CW-1:0] prev_q;
   logic [CW-1:0] prev_d;
   logic [CW-1:0] prev_inc;

   always_comb begin
      prev_d   = count;
      prev_inc = prev_q + 1'b1;
      boundary = (prev_q == '1) && (count == '0);
      disc     = (count != prev_q) && (count != prev_inc);
   end

   always_ff @(posedge clk) begin
      if (!rst) prev_q <= '0;
      else      prev_q <= prev_d;
   end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator slaved to an upstream free-running counter, with a
// shadowed duty register applied only at period boundaries.
module count_pwm_gen
   import count_pwm_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] count,
   input  logic          en,
   input  logic [CW-1:0] duty_in,
   input  logic          duty_wr,
   input  logic          err_clr,
   output logic          pwm,
   output logic          wrap,
   output logic [CW-1:0] duty_act,
   output logic [PW-1:0] periods,
   output logic          seq_err,
   output logic [1:0]    state
);

   logic          boundary;
   logic          disc;
   logic          load;

   logic [1:0]    state_q, state_d;
   logic          pwm_q, pwm_d;
   logic          wrap_q, wrap_d;
   logic [CW-1:0] duty_act_q, duty_act_d;
   logic [CW-1:0] pending_q, pending_d;
   logic          pend_v_q, pend_v_d;
   logic [PW-1:0] periods_q, periods_d;
   logic          seq_err_q, seq_err_d;

   count_seq_detect #(.CW(CW)) u_seq (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .boundary (boundary),
      .disc     (disc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (en) state_d = ST_ARM;
         ST_ARM: begin
            if (!en)           state_d = ST_IDLE;
            else if (boundary) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en) state_d = boundary ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (boundary) state_d = ST_IDLE;
            else if (en)  state_d = ST_RUN;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // A write on the boundary edge lands in pending for the next period.
   always_comb begin
      load = boundary && pend_v_q &&
             (state_q == ST_ARM || state_q == ST_RUN);
      pending_d  = duty_wr ? duty_in : pending_q;
      pend_v_d   = duty_wr ? 1'b1 : (load ? 1'b0 : pend_v_q);
      duty_act_d = load ? pending_q : duty_act_q;
   end

   always_comb begin
      pwm_d  = (state_d == ST_RUN || state_d == ST_DRAIN) &&
               (count < duty_act_d);
      wrap_d = boundary;
      periods_d = periods_q;
      if (boundary && periods_q != '1 &&
          (state_q == ST_RUN || state_q == ST_DRAIN))
         periods_d = periods_q + 1'b1;
      seq_err_d = disc ? 1'b1 : (err_clr ? 1'b0 : seq_err_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         pwm_q      <= 1'b0;
         wrap_q     <= 1'b0;
         duty_act_q <= '0;
         pending_q  <= '0;
         pend_v_q   <= 1'b0;
         periods_q  <= '0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pwm_q      <= pwm_d;
         wrap_q     <= wrap_d;
         duty_act_q <= duty_act_d;
         pending_q  <= pending_d;
         pend_v_q   <= pend_v_d;
         periods_q  <= periods_d;
         seq_err_q  <= seq_err_d;
      end
   end

   assign pwm      = pwm_q;
   assign wrap     = wrap_q;
   assign duty_act = duty_act_q;
   assign periods  = periods_q;
   assign seq_err  = seq_err_q;
   assign state    = state_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen: arm/run/drain, duty shadowing,
// discontinuity flag, mid-period reset and duty extremes.
module tb_count_pwm_gen;
   import count_pwm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   count_pwm_if #(.CW(4), .PW(8)) bus ();

   count_pwm_gen #(.CW(4), .PW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .count    (bus.count),
      .en       (bus.en),
      .duty_in  (bus.duty_in),
      .duty_wr  (bus.duty_wr),
      .err_clr  (bus.err_clr),
      .pwm      (bus.pwm),
      .wrap     (bus.wrap),
      .duty_act (bus.duty_act),
      .periods  (bus.periods),
      .seq_err  (bus.seq_err),
      .state    (bus.state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic [3:0] c);
      bus.count = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_state"},   32'(bus.state),    32'd0);
      chk({tag, "_pwm"},     32'(bus.pwm),      32'd0);
      chk({tag, "_wrap"},    32'(bus.wrap),     32'd0);
      chk({tag, "_duty"},    32'(bus.duty_act), 32'd0);
      chk({tag, "_periods"}, 32'(bus.periods),  32'd0);
      chk({tag, "_seqerr"},  32'(bus.seq_err),  32'd0);
   endtask

   initial begin
      bus.count   = 4'd0;
      bus.en      = 1'b0;
      bus.duty_in = 4'd0;
      bus.duty_wr = 1'b0;
      bus.err_clr = 1'b0;

      // reset
      tick(4'd0);
      tick(4'd0);
      chk_zero("reset");

      // program duty 5, enable -> ARM
      rst = 1'b1;
      bus.duty_wr = 1'b1;
      bus.duty_in = 4'd5;
      bus.en      = 1'b1;
      tick(4'd0);
      bus.duty_wr = 1'b0;
      chk("arm_state", 32'(bus.state), 32'(ST_ARM));
      chk("arm_duty",  32'(bus.duty_act), 32'd0);
      for (int c = 1; c < 16; c++) tick(4'(c));
      chk("arm_hold_state", 32'(bus.state), 32'(ST_ARM));
      chk("arm_hold_pwm",   32'(bus.pwm), 32'd0);

      // first RUN period, duty 5
      for (int c = 0; c < 16; c++) begin
         tick(4'(c));
         chk($sformatf("p1_pwm_c%0d", c), 32'(bus.pwm),
             32'(c < 5));
         chk($sformatf("p1_wrap_c%0d", c), 32'(bus.wrap),
             32'(c == 0));
      end
      chk("p1_state",   32'(bus.state), 32'(ST_RUN));
      chk("p1_duty",    32'(bus.duty_act), 32'd5);
      chk("p1_periods", 32'(bus.periods), 32'd0);

      // period 2: write 12 at count 7, current period stays 5
      for (int c = 0; c < 16; c++) begin
         if (c == 7) begin
            bus.duty_wr = 1'b1;
            bus.duty_in = 4'd12;
         end
         tick(4'(c));
         bus.duty_wr = 1'b0;
         chk($sformatf("p2_pwm_c%0d", c), 32'(bus.pwm),
             32'(c < 5));
      end
      chk("p2_duty_before", 32'(bus.duty_act), 32'd5);
      chk("p2_periods",     32'(bus.periods), 32'd1);

      // period 3 uses 12
      tick(4'd0);
      chk("p3_duty_after", 32'(bus.duty_act), 32'd12);
      chk("p3_periods",    32'(bus.periods), 32'd2);
      for (int c = 1; c < 16; c++) begin
         tick(4'(c));
         chk($sformatf("p3_pwm_c%0d", c), 32'(bus.pwm),
             32'(c < 12));
      end

      // period 4: drop en at count 3 -> DRAIN, finish, IDLE
      tick(4'd0);
      chk("p4_periods", 32'(bus.periods), 32'd3);
      tick(4'd1);
      tick(4'd2);
      bus.en = 1'b0;
      tick(4'd3);
      chk("drain_state", 32'(bus.state), 32'(ST_DRAIN));
      chk("drain_pwm3",  32'(bus.pwm), 32'd1);
      for (int c = 4; c < 16; c++) begin
         tick(4'(c));
         chk($sformatf("drain_pwm_c%0d", c), 32'(bus.pwm),
             32'(c < 12));
      end
      chk("drain_state_end", 32'(bus.state), 32'(ST_DRAIN));
      tick(4'd0);
      chk("idle_state",   32'(bus.state), 32'(ST_IDLE));
      chk("idle_pwm",     32'(bus.pwm), 32'd0);
      chk("idle_wrap",    32'(bus.wrap), 32'd1);
      chk("idle_periods", 32'(bus.periods), 32'd4);

      // discontinuity 6 -> 11
      for (int c = 1; c < 7; c++) tick(4'(c));
      chk("seq_pre", 32'(bus.seq_err), 32'd0);
      tick(4'd11);
      chk("seq_set", 32'(bus.seq_err), 32'd1);
      tick(4'd12);
      chk("seq_sticky", 32'(bus.seq_err), 32'd1);
      bus.err_clr = 1'b1;
      tick(4'd13);
      bus.err_clr = 1'b0;
      chk("seq_clr",  32'(bus.seq_err), 32'd0);
      chk("seq_duty", 32'(bus.duty_act), 32'd12);

      // duty 0 for two periods, then duty 15
      bus.en      = 1'b1;
      bus.duty_wr = 1'b1;
      bus.duty_in = 4'd0;
      tick(4'd14);
      bus.duty_wr = 1'b0;
      chk("d0_arm", 32'(bus.state), 32'(ST_ARM));
      tick(4'd15);
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < 16; c++) begin
            if (p == 1 && c == 8) begin
               bus.duty_wr = 1'b1;
               bus.duty_in = 4'd15;
            end
            tick(4'(c));
            bus.duty_wr = 1'b0;
            chk($sformatf("d0_p%0d_pwm_c%0d", p, c),
                32'(bus.pwm), 32'd0);
         end
      end
      chk("d0_duty",    32'(bus.duty_act), 32'd0);
      chk("d0_periods", 32'(bus.periods), 32'd5);
      for (int c = 0; c < 16; c++) begin
         tick(4'(c));
         chk($sformatf("d15_pwm_c%0d", c), 32'(bus.pwm),
             32'(c != 15));
      end
      chk("d15_duty",    32'(bus.duty_act), 32'd15);
      chk("d15_periods", 32'(bus.periods), 32'd6);

      // reset mid-period at count 2
      tick(4'd0);
      tick(4'd1);
      chk("pre_rst_pwm", 32'(bus.pwm), 32'd1);
      rst = 1'b0;
      tick(4'd2);
      chk_zero("midrst");

      // first edge after release: prev=0 vs count 5
      rst = 1'b1;
      bus.en = 1'b0;
      tick(4'd5);
      chk("rel_seqerr", 32'(bus.seq_err), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
